alu_scheduler: RTL

Two-requester round-robin scheduler that shares the single registered ALU between the fetch unit (requester 0, PC arithmetic) and the execute unit (requester 1, data operations). It grants one requester at a time, drives `alu_sel` and the operands for exactly one ALU clock, and captures the registered result together with the `lsb` and `neg` flags. It then returns the result to the granted requester with a one-cycle completion pulse. It sits between the control unit and the ALU; nothing else drives the ALU select or operand inputs.

---
 rtl/alu_scheduler_if.sv | 57 +++++
 rtl/alu_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler_if.sv
// alu_scheduler_if: bundle for the two-requester ALU scheduler.
//
// Purpose: groups the requester handshakes, the result/status outputs and the
// ALU-facing select/operand/result signals of alu_scheduler.
//
// Signals:
//   req0/req1, op0/op1, a0/b0/a1/b1  requester side, into the scheduler
//   gnt0/gnt1, done0/done1           one-cycle grant / completion pulses
//   result, res_lsb, res_neg, err    completion data and status
//   busy                             scheduler not in IDLE
//   alu_sel, alu_a, alu_b            scheduler -> ALU
//   alu_c, alu_lsb, alu_neg          ALU -> scheduler
//
// Modports:
//   slave  - scheduler view
//   master - environment view (requesters and ALU)
interface alu_scheduler_if #(
    parameter int WIDTH = 18
);
    logic             req0;
    logic             req1;
    logic [3:0]       op0;
    logic [3:0]       op1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic [WIDTH-1:0] result;
    logic             res_lsb;
    logic             res_neg;
    logic             err;
    logic             busy;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_c;
    logic             alu_lsb;
    logic             alu_neg;

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1,
        input  alu_c, alu_lsb, alu_neg,
        output gnt0, gnt1, done0, done1, result, res_lsb, res_neg, err, busy,
        output alu_sel, alu_a, alu_b
    );

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1,
        output alu_c, alu_lsb, alu_neg,
        input  gnt0, gnt1, done0, done1, result, res_lsb, res_neg, err, busy,
        input  alu_sel, alu_a, alu_b
    );
endinterface

// File: rtl/alu_scheduler.sv
// alu_scheduler: two-requester round-robin scheduler for the shared
// registered ALU (requester 0 = fetch unit, requester 1 = execute unit).
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    alu_scheduler_if.slave (requests, grants, completion, ALU side)
//
// Optional feature macro: ALU_DIVZERO_CHK_EN
//   defined   - opcode 4'b1100 with a == 0 is rejected (err=1, result all ones)
//   undefined - division by zero is issued to the ALU like any legal op
//
// Cycle plan (all outputs registered):
//   legal op : IDLE -grant-> ISSUE -> WAIT -> DONE -> IDLE
//   rejected : IDLE -grant-> ISSUE -> DONE -> IDLE   (alu_sel stays 0)
module alu_scheduler #(
    parameter int WIDTH = 18
) (
    input logic            clk,
    input logic            rst_n,
    alu_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;      // requester granted last
    logic             who_q, who_d;        // requester currently served
    logic             rej_q, rej_d;        // current op rejected, not issued
    logic             rej_ones_q, rej_ones_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [3:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             lsb_q, lsb_d;
    logic             neg_q, neg_d;

    // Arbitration candidate
    logic             pick1;
    logic [3:0]       cand_op;
    logic [WIDTH-1:0] cand_a;
    logic [WIDTH-1:0] cand_b;
    logic             cand_rej;
    logic             cand_ones;

    always_comb begin
        // On a tie the requester not granted last wins.
        pick1     = bus.req1 && (!bus.req0 || !last_q);
        cand_op   = pick1 ? bus.op1 : bus.op0;
        cand_a    = pick1 ? bus.a1  : bus.a0;
        cand_b    = pick1 ? bus.b1  : bus.b0;
        cand_rej  = (cand_op == 4'b0000) || (cand_op >= 4'b1110);
        cand_ones = 1'b0;
`ifdef ALU_DIVZERO_CHK_EN
        if (cand_op == 4'b1100 && cand_a == '0) begin
            cand_rej  = 1'b1;
            cand_ones = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        who_d      = who_q;
        rej_d      = rej_q;
        rej_ones_d = rej_ones_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        err_d      = 1'b0;
        alu_sel_d  = 4'b0000;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        result_d   = result_q;
        lsb_d      = lsb_q;
        neg_d      = neg_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt0_d     = !pick1;
                    gnt1_d     = pick1;
                    last_d     = pick1;
                    who_d      = pick1;
                    rej_d      = cand_rej;
                    rej_ones_d = cand_ones;
                    alu_a_d    = cand_a;
                    alu_b_d    = cand_b;
                    // alu_sel is registered, so loading it here makes the
                    // ISSUE cycle the single cycle the ALU sees the opcode.
                    alu_sel_d  = cand_rej ? 4'b0000 : cand_op;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rej_q) begin
                    done0_d  = !who_q;
                    done1_d  = who_q;
                    err_d    = 1'b1;
                    result_d = rej_ones_q ? '1 : '0;
                    lsb_d    = 1'b0;
                    neg_d    = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                done0_d  = !who_q;
                done1_d  = who_q;
                result_d = bus.alu_c;
                lsb_d    = bus.alu_lsb;
                neg_d    = bus.alu_neg;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b1;
            who_q      <= 1'b0;
            rej_q      <= 1'b0;
            rej_ones_q <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            alu_sel_q  <= 4'b0000;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            result_q   <= '0;
            lsb_q      <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            who_q      <= who_d;
            rej_q      <= rej_d;
            rej_ones_q <= rej_ones_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            alu_sel_q  <= alu_sel_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            result_q   <= result_d;
            lsb_q      <= lsb_d;
            neg_q      <= neg_d;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;
    assign bus.alu_sel = alu_sel_q;
    assign bus.alu_a   = alu_a_q;
    assign bus.alu_b   = alu_b_q;
    assign bus.result  = result_q;
    assign bus.res_lsb = lsb_q;
    assign bus.res_neg = neg_q;

endmodule
